// File: rtl/divisor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divisor_pkg
// Purpose  : Shared types and constants for the sequential restoring divider.
//            - state_e    : FSM state encoding (IDLE, RUN, DONE)
//            - DIV_WIDTH  : default operand/quotient/remainder width
//            - CNT_WIDTH  : iteration counter width for DIV_WIDTH
//            - cnt_width(): counter width for an arbitrary WIDTH
// Revision : 1.0 - initial release
// ============================================================================
package divisor_pkg;

  localparam int DIV_WIDTH = 4;

  // At least one bit so that WIDTH=1 still gets a legal counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/comparador_ge.sv
`default_nettype none
// ============================================================================
// Module   : comparador_ge
// Purpose  : Combinational unsigned magnitude comparison, ge = (a >= b).
// Ports    : a  [WIDTH-1:0] in  - left operand
//            b  [WIDTH-1:0] in  - right operand
//            ge            out - 1 when a >= b (unsigned)
// Revision : 1.0 - initial release
// ============================================================================
module comparador_ge
  import divisor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge
);

  assign ge = (a >= b);

endmodule
`default_nettype wire

// File: rtl/divisor_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : divisor_sequencial
// Purpose  : Unsigned restoring divider, one quotient bit per clock, MSB first.
//            A start accepted in IDLE or in the DONE cycle captures the
//            operands; WIDTH cycles later quociente/resto are latched and
//            done pulses for one cycle.
// Ports    : clk        in   rising-edge clock
//            rst        in   asynchronous active-high reset
//            start      in   request (sampled in IDLE / DONE only)
//            dividendo  in   [WIDTH-1:0] dividend
//            divisor    in   [WIDTH-1:0] divisor
//            quociente  out  [WIDTH-1:0] quotient (registered, held)
//            resto      out  [WIDTH-1:0] remainder (registered, held)
//            busy       out  high while in RUN
//            done       out  one-cycle result strobe
//            div_zero   out  last operation had a zero divisor
// Config   : DIVISOR_ZERO_TRAP_EN - when defined, a zero divisor skips the
//            iterations and completes one cycle after the start with
//            quociente=all ones, resto=dividendo, div_zero=1. When undefined
//            the normal iterations run and div_zero stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;         // dividend, shifted out MSB first
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  // The restored remainder is always < divisor, so it fits in WIDTH bits;
  // only the shifted value R' needs the extra bit.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_sh_q, quo_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quociente_q, quociente_d;
  logic [WIDTH-1:0]   resto_q, resto_d;
  logic               div_zero_q, div_zero_d;
  logic               trap_q, trap_d;       // zero-divisor completion pending

  logic               accept;
  logic               zero_trap;
  logic [WIDTH:0]     rem_shift;
  logic               ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               last_iter;

  // Start is only honoured when idle or in the done cycle; a pending
  // zero-divisor completion also blocks it.
  assign accept = start && !trap_q && (state_q == IDLE || state_q == DONE);

`ifdef DIVISOR_ZERO_TRAP_EN
  assign zero_trap = accept && (divisor == '0);
`else
  assign zero_trap = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};

  comparador_ge #(
    .WIDTH (WIDTH + 1)
  ) u_cmp (
    .a  (rem_shift),
    .b  ({1'b0, dvs_q}),
    .ge (ge)
  );

  // When ge is set, R' - divisor < divisor, so WIDTH-bit wrap-around
  // subtraction yields the exact result.
  assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
  assign rem_next  = ge ? rem_sub : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_sh_q[WIDTH-2:0], ge};
  assign last_iter = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (trap_q) begin
          state_d = DONE;
        end else if (accept && !zero_trap) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A zero-divisor trap taken here waits one cycle in IDLE.
        state_d = (accept && !zero_trap) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    quociente = quociente_q;
    resto     = resto_q;
    div_zero  = div_zero_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_sh_d    = quo_sh_q;
    cnt_d       = cnt_q;
    quociente_d = quociente_q;
    resto_d     = resto_q;
    div_zero_d  = div_zero_q;
    trap_d      = zero_trap;

    if (accept) begin
      dvd_d    = dividendo;
      dvs_d    = divisor;
      rem_d    = '0;
      quo_sh_d = '0;
      cnt_d    = CNT_W'(WIDTH - 1);
    end else if (state_q == RUN) begin
      dvd_d    = {dvd_q[WIDTH-2:0], 1'b0};
      rem_d    = rem_next;
      quo_sh_d = quo_next;
      cnt_d    = cnt_q - 1'b1;
      if (last_iter) begin
        quociente_d = quo_next;
        resto_d     = rem_next;
        div_zero_d  = 1'b0;
      end
    end

    if (trap_q) begin
      quociente_d = '1;
      resto_d     = dvd_q;
      div_zero_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_sh_q    <= '0;
      cnt_q       <= '0;
      quociente_q <= '0;
      resto_q     <= '0;
      div_zero_q  <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_sh_q    <= quo_sh_d;
      cnt_q       <= cnt_d;
      quociente_q <= quociente_d;
      resto_q     <= resto_d;
      div_zero_q  <= div_zero_d;
      trap_q      <= trap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divisor_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_divisor_sequencial
// Purpose  : Self-checking bench for divisor_sequencial. A cycle-level model
//            built from operation start times and plain integer division
//            predicts busy/done/results; directed cases pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divisor_sequencial;

  localparam int W = 4;
`ifdef DIVISOR_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic [W-1:0] quociente;
  logic [W-1:0] resto;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  divisor_sequencial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  // --------------------------------------------------------------------------
  // Reference model: an operation accepted at edge 'acc' with latency 'lat'
  // is busy for edges acc..acc+lat-1, done after edge acc+lat, and a new
  // start can be taken at edge acc+lat+1 or later.
  // --------------------------------------------------------------------------
  int           e_cnt = 0;
  int           acc   = 0;
  int           lat_m = 0;
  bit           active = 1'b0;
  bit           zop    = 1'b0;
  logic [W-1:0] ma, mb, mq, mr;
  bit           mdz, mbusy, mdone;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 1'b0;
      mq = '0; mr = '0; mdz = 1'b0; mbusy = 1'b0; mdone = 1'b0;
    end else begin
      e_cnt++;
      if (start && (!active || e_cnt >= acc + lat_m + 1)) begin
        active = 1'b1;
        acc    = e_cnt;
        ma     = dividendo;
        mb     = divisor;
        zop    = TRAP && (divisor == 0);
        lat_m  = zop ? 1 : W;
      end
      mbusy = active && !zop && e_cnt >= acc && e_cnt < acc + lat_m;
      mdone = active && e_cnt == acc + lat_m;
      if (mdone) begin
        if (mb == 0) begin
          mq  = '1;
          mr  = ma;
          mdz = TRAP;
        end else begin
          mq  = ma / mb;
          mr  = ma % mb;
          mdz = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({busy, done, div_zero, quociente, resto} !== {mbusy, mdone, mdz, mq, mr}) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got busy=%b done=%b dz=%b q=%0d r=%0d, expected busy=%b done=%b dz=%b q=%0d r=%0d",
                 $time, busy, done, div_zero, quociente, resto, mbusy, mdone, mdz, mq, mr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividendo = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividendo = W'($urandom); divisor = W'($urandom);
  endtask

  // Called just after the accepting edge; returns cycles until done and the
  // number of sampled cycles with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    if (done !== 1'b1) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: done not seen after %0d cycles, required within 20", lat);
    end
  endtask

  initial begin
    int lat, bc, nd;
    rst = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_q",    quociente, 0);
    check("reset_r",    resto,     0);
    check("reset_busy", busy,      0);
    check("reset_done", done,      0);
    check("reset_dz",   div_zero,  0);
    @(negedge clk);
    rst = 1'b0;

    // 13 / 3
    issue(4'd13, 4'd3);
    wait_done(lat, bc);
    check("13_3_lat",  lat, 4);
    check("13_3_busy", bc,  4);
    check("13_3_q",    quociente, 4);
    check("13_3_r",    resto,     1);
    check("model_13_3_q", mq, 4);

    // 15 / 15 then 0 / 5 started in the done cycle
    issue(4'd15, 4'd15);
    wait_done(lat, bc);
    check("15_15_q", quociente, 1);
    check("15_15_r", resto,     0);
    start = 1'b1; dividendo = 4'd0; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0; dividendo = 4'd9; divisor = 4'd9;
    wait_done(lat, bc);
    check("b2b_lat", lat, 4);
    check("0_5_q",   quociente, 0);
    check("0_5_r",   resto,     0);

    // 7 / 0
    issue(4'd7, 4'd0);
    wait_done(lat, bc);
    check("7_0_lat",  lat, TRAP ? 1 : 4);
    check("7_0_busy", bc,  TRAP ? 0 : 4);
    check("7_0_q",    quociente, 15);
    check("7_0_r",    resto,     7);
    check("7_0_dz",   div_zero,  TRAP ? 1 : 0);

    // 9 / 2 with a start during RUN that must be ignored
    issue(4'd9, 4'd2);
    @(negedge clk);
    start = 1'b1; dividendo = 4'd15; divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("9_2_lat", lat, 2);
    check("9_2_q",   quociente, 4);
    check("9_2_r",   resto,     1);

    // Reset in the middle of 14 / 3
    issue(4'd14, 4'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_q",    quociente, 0);
    check("arst_r",    resto,     0);
    check("arst_busy", busy,      0);
    check("arst_done", done,      0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);
    issue(4'd14, 4'd3);
    wait_done(lat, bc);
    check("14_3_q", quociente, 4);
    check("14_3_r", resto,     2);

    // All operand pairs with a non-zero divisor
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(W'(a), W'(b));
        wait_done(lat, bc);
        check("exh_q", quociente, a / b);
        check("exh_r", resto,     a % b);
      end
    end

    // Random start traffic, including starts during RUN and in DONE
    repeat (400) begin
      @(negedge clk);
      start     = ($urandom_range(0, 2) == 0);
      dividendo = W'($urandom);
      divisor   = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
